// File: rtl/bcd_operand_loader.sv
// rtl/bcd_operand_loader.sv - digit-serial BCD operand loader for the n-digit BCD adder
// Assembles A then B (MSD first) plus carry-in, and holds them until the consumer acks.
module bcd_operand_loader #(
  parameter int n = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 digit_in,
  input  logic                       digit_valid,
  output logic                       digit_ready,
  input  logic                       op_next,
  input  logic                       cin_in,
  input  logic                       clear,
  output logic [4*n-1:0]             A,
  output logic [4*n-1:0]             B,
  output logic                       cin,
  output logic                       op_valid,
  input  logic                       op_ack,
  output logic                       err,
  output logic [$clog2(n+1)-1:0]     digit_cnt
);

  localparam int CW = $clog2(n+1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t         state;
  logic           take;
  logic           legal;
  logic           accept;
  logic           last_digit;
  logic           complete;
  logic [4*n-1:0] a_shift;
  logic [4*n-1:0] b_shift;

  assign digit_ready = (state != HOLD);

  assign take       = digit_valid & digit_ready;
  assign legal      = (digit_in <= 4'd9);
  assign accept     = take & legal;
  assign last_digit = accept & (digit_cnt == CW'(n - 1));
  // A same-cycle op_next and n-th digit still produce a single completion.
  assign complete   = digit_ready & (op_next | last_digit);

  assign a_shift = (A << 4) | (4*n)'(digit_in);
  assign b_shift = (B << 4) | (4*n)'(digit_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD_A;
      A         <= '0;
      B         <= '0;
      cin       <= 1'b0;
      digit_cnt <= '0;
      op_valid  <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      state     <= LOAD_A;
      A         <= '0;
      B         <= '0;
      cin       <= 1'b0;
      digit_cnt <= '0;
      op_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= take & ~legal;
      case (state)
        LOAD_A: begin
          if (accept) A <= a_shift;
          if (complete) begin
            digit_cnt <= '0;
            state     <= LOAD_B;
          end else if (accept) begin
            digit_cnt <= digit_cnt + CW'(1);
          end
        end
        LOAD_B: begin
          if (accept) B <= b_shift;
          if (complete) begin
            digit_cnt <= '0;
            cin       <= cin_in;
            op_valid  <= 1'b1;
            state     <= HOLD;
          end else if (accept) begin
            digit_cnt <= digit_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (op_ack) begin
            A        <= '0;
            B        <= '0;
            cin      <= 1'b0;
            op_valid <= 1'b0;
            state    <= LOAD_A;
          end
        end
        default: begin
          state     <= LOAD_A;
          digit_cnt <= '0;
          op_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// tb/tb_bcd_operand_loader.sv - self-checking bench for bcd_operand_loader
// Directed scenarios plus a randomized run against an arithmetic operand model.
module tb_bcd_operand_loader;

  localparam int N  = 3;
  localparam int CW = $clog2(N+1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [3:0]      digit_in = '0;
  logic            digit_valid = 1'b0;
  logic            digit_ready;
  logic            op_next = 1'b0;
  logic            cin_in = 1'b0;
  logic            clear = 1'b0;
  logic [4*N-1:0]  A;
  logic [4*N-1:0]  B;
  logic            cin;
  logic            op_valid;
  logic            op_ack = 1'b0;
  logic            err;
  logic [CW-1:0]   digit_cnt;

  int checks = 0;
  int failures = 0;

  bcd_operand_loader #(.n(N)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .op_next(op_next), .cin_in(cin_in), .clear(clear),
    .A(A), .B(B), .cin(cin), .op_valid(op_valid), .op_ack(op_ack), .err(err),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 time unit after the capturing edge with inputs idled.
  task automatic cyc(input logic v, input logic [3:0] d, input logic nx,
                     input logic ci, input logic ak, input logic cl);
    digit_valid = v; digit_in = d; op_next = nx; cin_in = ci; op_ack = ak; clear = cl;
    @(posedge clk); #1;
    digit_valid = 1'b0; digit_in = '0; op_next = 1'b0; cin_in = 1'b0; op_ack = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (A !== 12'h000) begin failures++; $display("FAIL reset_A got=%h exp=000", A); end
    checks++; if (B !== 12'h000) begin failures++; $display("FAIL reset_B got=%h exp=000", B); end
    checks++; if (cin !== 1'b0) begin failures++; $display("FAIL reset_cin got=%b exp=0", cin); end
    checks++; if (digit_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", digit_cnt); end
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (digit_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", digit_ready); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_basic;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    checks++; if (digit_cnt !== 2) begin failures++; $display("FAIL basic_cnt2 got=%0d exp=2", digit_cnt); end
    cyc(1, 3, 0, 0, 0, 0);
    checks++; if (digit_cnt !== 0 || digit_ready !== 1'b1) begin failures++; $display("FAIL basic_a_done cnt=%0d ready=%b exp cnt=0 ready=1", digit_cnt, digit_ready); end
    cyc(1, 4, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", op_valid); end
    cyc(1, 6, 0, 0, 0, 0);
    checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", op_valid); end
    checks++; if (A !== 12'h123 || B !== 12'h456 || cin !== 1'b0) begin failures++; $display("FAIL basic_ops A=%h B=%h cin=%b exp 123 456 0", A, B, cin); end
    checks++; if (digit_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_hold got=%b exp=0", digit_ready); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (op_valid !== 1'b0 || A !== 12'h000 || B !== 12'h000 || digit_ready !== 1'b1) begin failures++; $display("FAIL basic_ack valid=%b A=%h B=%h ready=%b exp 0 000 000 1", op_valid, A, B, digit_ready); end
  endtask

  task automatic test_op_next;
    cyc(1, 9, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (A !== 12'h009 || digit_cnt !== 0) begin failures++; $display("FAIL opnext_A A=%h cnt=%0d exp 009 0", A, digit_cnt); end
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 9, 0, 1, 0, 0);
    checks++; if (A !== 12'h009 || B !== 12'h999 || cin !== 1'b1 || op_valid !== 1'b1) begin failures++; $display("FAIL opnext_ops A=%h B=%h cin=%b valid=%b exp 009 999 1 1", A, B, cin, op_valid); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (cin !== 1'b0 || op_valid !== 1'b0) begin failures++; $display("FAIL opnext_ack cin=%b valid=%b exp 0 0", cin, op_valid); end
  endtask

  task automatic test_err;
    cyc(1, 4'hC, 0, 0, 0, 0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", err); end
    checks++; if (A !== 12'h000 || digit_cnt !== 0) begin failures++; $display("FAIL err_unchanged A=%h cnt=%0d exp 000 0", A, digit_cnt); end
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", err); end
    cyc(1, 7, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    checks++; if (A !== 12'h702 || err !== 1'b0) begin failures++; $display("FAIL err_followup A=%h err=%b exp 702 0", A, err); end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_same_cycle;
    cyc(1, 5, 1, 0, 0, 0);
    checks++; if (A !== 12'h005 || digit_cnt !== 0 || digit_ready !== 1'b1 || op_valid !== 1'b0) begin failures++; $display("FAIL same_A A=%h cnt=%0d ready=%b valid=%b exp 005 0 1 0", A, digit_cnt, digit_ready, op_valid); end
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (B !== 12'h000 || op_valid !== 1'b1 || A !== 12'h005) begin failures++; $display("FAIL same_B A=%h B=%h valid=%b exp 005 000 1", A, B, op_valid); end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    cyc(1, 3, 1, 0, 0, 0);
    checks++; if (A !== 12'h123 || op_valid !== 1'b0 || digit_ready !== 1'b1) begin failures++; $display("FAIL same_nth A=%h valid=%b ready=%b exp 123 0 1", A, op_valid, digit_ready); end
    cyc(1, 8, 1, 0, 0, 0);
    checks++; if (B !== 12'h008 || op_valid !== 1'b1) begin failures++; $display("FAIL same_nth_B B=%h valid=%b exp 008 1", B, op_valid); end
  endtask

  task automatic test_hold;
    // Entered from test_same_cycle: A=123, B=008 in HOLD.
    cyc(1, 8, 1, 1, 0, 0);
    checks++; if (digit_ready !== 1'b0 || A !== 12'h123 || B !== 12'h008 || op_valid !== 1'b1 || cin !== 1'b0) begin failures++; $display("FAIL hold_stable ready=%b A=%h B=%h valid=%b cin=%b exp 0 123 008 1 0", digit_ready, A, B, op_valid, cin); end
    cyc(1, 8, 0, 0, 0, 0);
    checks++; if (op_valid !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL hold_wait valid=%b err=%b exp 1 0", op_valid, err); end
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (op_valid !== 1'b0 || A !== 12'h000) begin failures++; $display("FAIL hold_ack valid=%b A=%h exp 0 000", op_valid, A); end
  endtask

  task automatic test_clear;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    checks++; if (A !== 12'h012) begin failures++; $display("FAIL clear_pre A=%h exp 012", A); end
    cyc(1, 3, 1, 0, 0, 1);
    checks++; if (A !== 12'h000 || digit_cnt !== 0 || digit_ready !== 1'b1 || op_valid !== 1'b0) begin failures++; $display("FAIL clear_post A=%h cnt=%0d ready=%b valid=%b exp 000 0 1 0", A, digit_cnt, digit_ready, op_valid); end
    cyc(1, 4, 0, 0, 0, 0);
    checks++; if (A !== 12'h004 || B !== 12'h000) begin failures++; $display("FAIL clear_load_a A=%h B=%h exp 004 000", A, B); end
  endtask

  task automatic test_async_reset;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (A !== 12'h000 || B !== 12'h000 || cin !== 1'b0 || digit_cnt !== 0 || op_valid !== 1'b0 || err !== 1'b0 || digit_ready !== 1'b1) begin failures++; $display("FAIL async_rst A=%h B=%h cin=%b cnt=%0d valid=%b err=%b ready=%b", A, B, cin, digit_cnt, op_valid, err, digit_ready); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_random;
    int phase, cnt;
    longint ma, mb;
    logic mcin, merr;
    logic v, nx, ci, ak, cl;
    logic [3:0] d;
    cyc(0, 0, 0, 0, 0, 1);
    phase = 0; cnt = 0; ma = 0; mb = 0; mcin = 0; merr = 0;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 1) == 1);
      d  = 4'($urandom_range(0, 15));
      nx = ($urandom_range(0, 5) == 0);
      ci = 1'($urandom_range(0, 1));
      ak = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 39) == 0);
      merr = 0;
      if (cl) begin
        phase = 0; cnt = 0; ma = 0; mb = 0; mcin = 0;
      end else if (phase == 2) begin
        if (ak) begin phase = 0; ma = 0; mb = 0; mcin = 0; end
      end else begin
        if (v && d > 9) merr = 1;
        if (v && d <= 9) begin
          if (phase == 0) ma = ma * 16 + d; else mb = mb * 16 + d;
          cnt++;
        end
        if (nx || cnt == N) begin
          cnt = 0;
          if (phase == 1) mcin = ci;
          phase++;
        end
      end
      cyc(v, d, nx, ci, ak, cl);
      checks++; if (A !== (4*N)'(ma)) begin failures++; $display("FAIL rnd_A i=%0d got=%h exp=%h", i, A, (4*N)'(ma)); end
      checks++; if (B !== (4*N)'(mb)) begin failures++; $display("FAIL rnd_B i=%0d got=%h exp=%h", i, B, (4*N)'(mb)); end
      checks++; if (cin !== mcin) begin failures++; $display("FAIL rnd_cin i=%0d got=%b exp=%b", i, cin, mcin); end
      checks++; if (err !== merr) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err, merr); end
      checks++; if (digit_cnt !== CW'(cnt)) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, digit_cnt, cnt); end
      checks++; if (op_valid !== (phase == 2)) begin failures++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, op_valid, phase == 2); end
      checks++; if (digit_ready !== (phase != 2)) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, digit_ready, phase != 2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_op_next();
    test_err();
    test_same_cycle();
    test_hold();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
